// File: rtl/gpio_ports.sv
// rtl/gpio_ports.sv - memory-mapped GPIO ports with direction, sync inputs and edge IRQ flags
module gpio_ports #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0200,
    parameter int                    NUM_PORTS  = 2,
    parameter int                    EDGE_MODE  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [7:0]              data_in,
    input  logic                    write_enable,
    output logic [7:0]              data_out,
    output logic                    sel,
    input  logic [8*NUM_PORTS-1:0]  pins_in,
    output logic [8*NUM_PORTS-1:0]  pins_out,
    output logic [8*NUM_PORTS-1:0]  pins_oe,
    output logic                    irq
);
    localparam int                  PW      = 8 * NUM_PORTS;
    localparam logic [ADDR_WIDTH:0] WIN_LO  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] WIN_HI  = WIN_LO + (ADDR_WIDTH+1)'(4 * NUM_PORTS);
    localparam logic [4:0]          BASE_LO = BASE_ADDR[4:0];

    logic [PW-1:0] out_q, out_d;
    logic [PW-1:0] ddr_q, ddr_d;
    logic [PW-1:0] ien_q, ien_d;
    logic [PW-1:0] ifr_q, ifr_d;
    logic [PW-1:0] s1_q, s2_q, s3_q;
    logic [7:0]    data_out_q, data_out_d;
    logic          sel_q, sel_d;
    logic          irq_q;

    logic          hit;
    logic [4:0]    off;
    logic [2:0]    port_idx;
    logic [1:0]    reg_idx;
    logic [PW-1:0] rise, fall, edge_hit, clr;

    always_comb begin
        hit      = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
        // Only the low five offset bits matter since the window is at most 32 bytes.
        off      = addr[4:0] - BASE_LO;
        port_idx = off[4:2];
        reg_idx  = off[1:0];

        rise = s2_q & ~s3_q;
        fall = ~s2_q & s3_q;
        if (EDGE_MODE == 0) begin
            edge_hit = rise;
        end else if (EDGE_MODE == 1) begin
            edge_hit = fall;
        end else begin
            edge_hit = rise | fall;
        end

        out_d      = out_q;
        ddr_d      = ddr_q;
        ien_d      = ien_q;
        clr        = '0;
        data_out_d = 8'h00;
        sel_d      = hit;

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (hit && port_idx == 3'(p)) begin
                case (reg_idx)
                    2'd0:    data_out_d = (out_q[8*p +: 8] & ddr_q[8*p +: 8])
                                        | (s2_q[8*p +: 8] & ~ddr_q[8*p +: 8]);
                    2'd1:    data_out_d = ddr_q[8*p +: 8];
                    2'd2:    data_out_d = ien_q[8*p +: 8];
                    default: data_out_d = ifr_q[8*p +: 8];
                endcase
                if (write_enable) begin
                    case (reg_idx)
                        2'd0:    out_d[8*p +: 8] = data_in;
                        2'd1:    ddr_d[8*p +: 8] = data_in;
                        2'd2:    ien_d[8*p +: 8] = data_in;
                        default: clr[8*p +: 8]   = data_in;
                    endcase
                end
            end
        end

        // A new enabled edge wins over a write-1-clear of the same bit.
        ifr_d = (ifr_q & ~clr) | (edge_hit & ien_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= '0;
            ddr_q      <= '0;
            ien_q      <= '0;
            ifr_q      <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            data_out_q <= 8'h00;
            sel_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            ddr_q      <= ddr_d;
            ien_q      <= ien_d;
            ifr_q      <= ifr_d;
            s1_q       <= pins_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            data_out_q <= data_out_d;
            sel_q      <= sel_d;
            irq_q      <= |ifr_q;
        end
    end

    assign data_out = data_out_q;
    assign sel      = sel_q;
    assign pins_out = out_q;
    assign pins_oe  = ddr_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_gpio_ports.sv
// tb/tb_gpio_ports.sv - self-checking bench for gpio_ports against a per-edge behavioural model
module tb_gpio_ports;
    localparam int BASE = 'h0200;
    localparam int NP   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        write_enable;
    logic [7:0]  data_out;
    logic        sel;
    logic [15:0] pins_in;
    logic [15:0] pins_out;
    logic [15:0] pins_oe;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    gpio_ports #(
        .ADDR_WIDTH(16),
        .BASE_ADDR (16'h0200),
        .NUM_PORTS (NP),
        .EDGE_MODE (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .data_in     (data_in),
        .write_enable(write_enable),
        .data_out    (data_out),
        .sel         (sel),
        .pins_in     (pins_in),
        .pins_out    (pins_out),
        .pins_oe     (pins_oe),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register bytes per port plus a record of past pin samples.
    logic [7:0]  m_out[NP], m_ddr[NP], m_ien[NP], m_ifr[NP];
    logic [15:0] past1, past2, past3;
    logic [7:0]  e_dout;
    logic        e_sel, e_irq;

    always @(posedge clk) begin
        int          off, p, r;
        logic [15:0] rose;
        if (reset) begin
            for (int i = 0; i < NP; i++) begin
                m_out[i] = 0; m_ddr[i] = 0; m_ien[i] = 0; m_ifr[i] = 0;
            end
            past1 = 0; past2 = 0; past3 = 0;
            e_dout = 0; e_sel = 0; e_irq = 0;
        end else begin
            e_irq = 1'b0;
            for (int i = 0; i < NP; i++) if (m_ifr[i] != 0) e_irq = 1'b1;
            off = int'(addr) - BASE;
            e_sel = (off >= 0) && (off < 4*NP);
            e_dout = 8'h00;
            p = off / 4;
            r = off % 4;
            if (e_sel) begin
                if (r == 0)      e_dout = (m_out[p] & m_ddr[p]) | (past2[8*p +: 8] & ~m_ddr[p]);
                else if (r == 1) e_dout = m_ddr[p];
                else if (r == 2) e_dout = m_ien[p];
                else             e_dout = m_ifr[p];
            end
            // The bit the core sees went 0 -> 1 between the samples taken three and two edges ago.
            rose = past2 & ~past3;
            for (int i = 0; i < NP; i++) begin
                logic [7:0] cleared;
                cleared = (e_sel && write_enable && p == i && r == 3) ? data_in : 8'h00;
                m_ifr[i] = (m_ifr[i] & ~cleared) | (rose[8*i +: 8] & m_ien[i]);
            end
            if (e_sel && write_enable) begin
                if (r == 0)      m_out[p] = data_in;
                else if (r == 1) m_ddr[p] = data_in;
                else if (r == 2) m_ien[p] = data_in;
            end
            past3 = past2; past2 = past1; past1 = pins_in;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cyc_pins_out", pins_out, {m_out[1], m_out[0]});
        chk("cyc_pins_oe", pins_oe, {m_ddr[1], m_ddr[0]});
        chk("cyc_irq", {15'h0, irq}, {15'h0, e_irq});
        chk("cyc_data_out", {8'h00, data_out}, {8'h00, e_dout});
        chk("cyc_sel", {15'h0, sel}, {15'h0, e_sel});
    end

    // One bus cycle; returns just after the edge that consumed the inputs.
    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic we);
        @(negedge clk);
        addr = a; data_in = d; write_enable = we;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(16'h0000, 8'h00, 1'b0);
    endtask

    initial begin
        reset = 1'b1; addr = 16'h0000; data_in = 8'h00; write_enable = 1'b0;
        pins_in = 16'hFFFF;

        cyc(16'h0201, 8'hFF, 1'b1);
        cyc(16'h0000, 8'h00, 1'b0);
        chk("rst_pins_out", pins_out, 16'h0000);
        chk("rst_pins_oe", pins_oe, 16'h0000);
        chk("rst_irq", {15'h0, irq}, 16'h0000);

        reset = 1'b0;
        idle(2);
        cyc(16'h0203, 8'h00, 1'b0);
        chk("rst_rd_ifr0", {8'h00, data_out}, 16'h0000);
        cyc(16'h0200, 8'h00, 1'b0);
        chk("rst_rd_data0", {8'h00, data_out}, 16'h00FF);
        chk("rst_rd_sel", {15'h0, sel}, 16'h0001);

        pins_in = 16'h3C00;
        cyc(16'h0205, 8'h0F, 1'b1);
        cyc(16'h0204, 8'hA5, 1'b1);
        chk("out_oe1", {8'h00, pins_oe[15:8]}, 16'h000F);
        chk("out_out1", {8'h00, pins_out[15:8]}, 16'h00A5);
        idle(2);
        cyc(16'h0204, 8'h00, 1'b0);
        chk("out_rd_data1", {8'h00, data_out}, 16'h0035);

        cyc(16'h0202, 8'h01, 1'b1);
        idle(3);
        pins_in[0] = 1'b1;
        idle(1);
        idle(1);
        idle(1);
        chk("irq_not_yet_k2", {15'h0, irq}, 16'h0000);
        cyc(16'h0203, 8'h00, 1'b0);
        chk("irq_ifr0", {8'h00, data_out}, 16'h0001);
        chk("irq_at_k3", {15'h0, irq}, 16'h0001);
        cyc(16'h0203, 8'h01, 1'b1);
        chk("irq_hold_clear_edge", {15'h0, irq}, 16'h0001);
        idle(1);
        chk("irq_dropped", {15'h0, irq}, 16'h0000);

        cyc(16'h0202, 8'h00, 1'b1);
        pins_in[1] = 1'b1;
        idle(4);
        cyc(16'h0203, 8'h00, 1'b0);
        chk("mask_ifr0", {8'h00, data_out}, 16'h0000);
        chk("mask_irq", {15'h0, irq}, 16'h0000);

        cyc(16'h0202, 8'h01, 1'b1);
        pins_in[0] = 1'b0;
        idle(4);
        pins_in[0] = 1'b1;
        idle(2);
        cyc(16'h0203, 8'h01, 1'b1);
        cyc(16'h0203, 8'h00, 1'b0);
        chk("coll_ifr0", {8'h00, data_out}, 16'h0001);
        chk("coll_irq", {15'h0, irq}, 16'h0001);
        idle(1);
        chk("coll_irq_stays", {15'h0, irq}, 16'h0001);

        cyc(16'h0208, 8'hFF, 1'b1);
        chk("dec_hi_dout", {8'h00, data_out}, 16'h0000);
        chk("dec_hi_sel", {15'h0, sel}, 16'h0000);
        cyc(16'h01FF, 8'hFF, 1'b1);
        chk("dec_lo_dout", {8'h00, data_out}, 16'h0000);
        chk("dec_lo_sel", {15'h0, sel}, 16'h0000);
        chk("dec_pins_out", pins_out, 16'hA500);
        chk("dec_pins_oe", pins_oe, 16'h0F00);
        cyc(16'h0202, 8'h00, 1'b0);
        chk("dec_ien0_kept", {8'h00, data_out}, 16'h0001);
        cyc(16'h0207, 8'h00, 1'b0);
        chk("dec_top_sel", {15'h0, sel}, 16'h0001);
        chk("dec_top_ifr1", {8'h00, data_out}, 16'h0000);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/gpio_ports.md
# gpio_ports

Memory-mapped, parametrised general-purpose I/O peripheral on the 65C02 bus, running in the CPU clock domain. Generalises the single fixed output port to NUM_PORTS 8-bit ports, each with a direction register, synchronised inputs, edge-detect interrupt flags and a combined level IRQ output intended for the CPU IRQ input. Read data is registered for the CPU's synchronous-read bus timing. A select flag lets the top level multiplex read data between peripherals.

## Interface
- BASE_ADDR, 16'h0200: first byte address of the register window.
- NUM_PORTS, 2: number of 8-bit ports, 1..8; the window is 4*NUM_PORTS bytes.
- ADDR_WIDTH, 16: CPU address bus width.
- EDGE_MODE, 0: edge that sets a flag; 0 = rising, 1 = falling, 2 = both.

Ports:
- clk  in  1  CPU clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  ADDR_WIDTH  CPU address.
- data_in  in  8  CPU write data.
- write_enable  in  1  CPU write strobe, sampled with addr.
- data_out  out  8  registered read data.
- sel  out  1  registered: previous-cycle addr fell inside the window.
- pins_in  in  8*NUM_PORTS  external inputs, asynchronous; port p is bits [8p+7:8p].
- pins_out  out  8*NUM_PORTS  output latch values.
- pins_oe  out  8*NUM_PORTS  per-bit output enable, equal to DDR.
- irq  out  1  active-high interrupt request, registered.

## Operation
- Decode: hit = BASE_ADDR <= addr < BASE_ADDR + 4*NUM_PORTS. off = addr - BASE_ADDR; port p = off >> 2; register r = off[1:0].
- Per-port registers, each 8 bits:
  - r=0 DATA: write updates OUT. Read returns, per bit, OUT where DDR=1, else the synchronised input.
  - r=1 DDR: 1 = output.
  - r=2 IEN: per-bit edge-interrupt enable.
  - r=3 IFR: read returns flags. Writing 1 clears the flag; writing 0 leaves it unchanged.
- Input path:
  - Two-flop synchroniser, s1 then s2, plus a previous-value flop s3.
  - Rising edge = s2 & ~s3. Falling edge = ~s2 & s3.
  - Edges are selected by EDGE_MODE.
- Flag set: IFR bit sets when its edge is detected AND its IEN bit = 1. Edges on disabled bits are discarded, not held pending.
- Edge detection ignores DDR, so an output driven back in on pins_in can still raise flags.
- Simultaneous flag set and write-1-clear on the same bit in the same cycle: set wins, and the flag stays 1.
- Writes to IEN do not alter IFR. Clearing an IEN bit leaves an already-set flag in place.
- irq = OR of all IFR bits across all ports, registered.
- Writes outside the window are ignored. Reads outside the window give data_out = 8'h00 and sel = 0.
- Reads have no side effects.

## Timing
- Read latency 1 cycle: addr presented in cycle n gives data_out and sel valid after edge n+1. Both are updated every cycle, regardless of write_enable.
- A read of DATA reflects register state before any write in the same cycle.
- Write: registers update on the edge where write_enable=1. pins_out and pins_oe change at that same edge.
- Input to flag latency: a pin change is stable before edge k, reaches s2 at k+1, the flag sets at k+2, and irq asserts at k+3.
- IFR clear at edge k: irq deasserts at k+1, provided no other flag is set.
- Reset, when active at an edge, drives these registers to 0: OUT, DDR, IEN, IFR, s1, s2, s3, data_out, sel and irq. A write in the same cycle is ignored.
- No spurious flags after reset, because IEN=0.
- Reset mid-operation discards pending flags and synchroniser state.

## Test plan
Parameters for all scenarios: BASE_ADDR=16'h0200, NUM_PORTS=2, EDGE_MODE=0.
- Reset values: hold reset 2 cycles with pins_in=16'hFFFF.
  - Required: pins_out=0, pins_oe=0 and irq=0.
  - Reading 16'h0203 returns 8'h00 and 16'h0200 returns 8'hFF.
- Output path: write 8'h0F to 16'h0205 (DDR1), then 8'hA5 to 16'h0204 (DATA1), with pins_in[15:8]=8'h3C.
  - Required: pins_oe[15:8]=8'h0F and pins_out[15:8]=8'hA5.
  - Reading 16'h0204 returns 8'h35, one cycle after addr.
- Edge interrupt: write 8'h01 to 16'h0202, then raise pins_in[0] at edge k.
  - Required: IFR0=8'h01 and irq=1 at k+3.
  - Writing 8'h01 to 16'h0203 drops irq the next cycle.
- Masked edge: with IEN0=8'h00, raise pins_in[1]. Required: IFR0 stays 8'h00 and irq stays 0.
- Set/clear collision: with IEN0=8'h01, time a write-1-clear of 16'h0203 to coincide with a new rising edge on bit 0. Required: IFR0=8'h01 and irq remains 1.
- Decode bounds:
  - Write 8'hFF to 16'h0208 and 16'h01FF. Required: no register changes, and reads of both give data_out=8'h00, sel=0.
  - Reading 16'h0207 gives sel=1.
